// File: rtl/disparity_writer.sv
// disparity_writer: disparity stream to frame-buffer write master.
// Optional stats counters built when DISP_WRITER_STATS_EN is defined.
module disparity_writer #(
    parameter int          DISP_BITS  = 6,
    parameter int          F_WIDTH    = 320,
    parameter int          F_HEIGHT   = 240,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          disparity_val,
    input  logic [DISP_BITS-1:0]          disparity,
    input  logic [9:0]                    in_x,
    input  logic [9:0]                    in_y,
    output logic [31:0]                   wr_address,
    output logic [7:0]                    wr_data,
    output logic                          wr_write,
    input  logic                          wr_waitrequest,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          bad_coord,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // stage 0
    logic                 s0_valid_q;
    logic [DISP_BITS-1:0] s0_disp_q;
    logic [9:0]           s0_x_q;
    logic [9:0]           s0_y_q;
    logic                 in_range;
    logic [31:0]          s0_addr;
    logic [7:0]           s0_data;
    logic                 s0_last;

    // fifo
    logic [31:0]      addr_mem [FIFO_DEPTH];
    logic [7:0]       data_mem [FIFO_DEPTH];
    logic             last_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // master
    state_t      state_q;
    logic [31:0] addr_q;
    logic [7:0]  data_q;
    logic        last_q;
    logic        write_q;
    logic        frame_done_q;
    logic        accept;

    // flags
    logic overflow_q, overflow_d;
    logic bad_q, bad_d;
    logic drop_ovf;
    logic drop_bad;

    // range check, address and display byte for the staged sample
    always_comb begin
        in_range = ({22'd0, in_x} < 32'(F_WIDTH)) &&
                   ({22'd0, in_y} < 32'(F_HEIGHT));
        s0_addr  = BASE_ADDR
                 + {22'd0, s0_y_q} * 32'(F_WIDTH)
                 + {22'd0, s0_x_q};
        s0_data  = 8'(s0_disp_q) << (8 - DISP_BITS);
        s0_last  = (s0_x_q == 10'(F_WIDTH - 1)) &&
                   (s0_y_q == 10'(F_HEIGHT - 1));
    end

    // stage 0 register; out-of-range samples never become valid
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_disp_q  <= '0;
            s0_x_q     <= '0;
            s0_y_q     <= '0;
        end else begin
            s0_valid_q <= disparity_val && in_range;
            if (disparity_val) begin
                s0_disp_q <= disparity;
                s0_x_q    <= in_x;
                s0_y_q    <= in_y;
            end
        end
    end

    // push/pop decisions, occupancy and sticky flag next state
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == DEPTH_L);
        accept     = (state_q == WRITE) && !wr_waitrequest;
        pop        = !fifo_empty && ((state_q == IDLE) || accept);
        push       = s0_valid_q && (!fifo_full || pop);
        drop_ovf   = s0_valid_q && !push;
        drop_bad   = disparity_val && !in_range;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        overflow_d = overflow_q || drop_ovf;
        bad_d      = bad_q || drop_bad;
    end

    // fifo storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= s0_addr;
            data_mem[wr_ptr_q] <= s0_data;
            last_mem[wr_ptr_q] <= s0_last;
        end
    end

    // fifo pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            bad_q      <= bad_d;
        end
    end

    // write master: holds one word until the slave stops stalling
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            write_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && last_q;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        addr_q  <= addr_mem[rd_ptr_q];
                        data_q  <= data_mem[rd_ptr_q];
                        last_q  <= last_mem[rd_ptr_q];
                        write_q <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (pop) begin
                            addr_q <= addr_mem[rd_ptr_q];
                            data_q <= data_mem[rd_ptr_q];
                            last_q <= last_mem[rd_ptr_q];
                        end else begin
                            write_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign wr_address = addr_q;
    assign wr_data    = data_q;
    assign wr_write   = write_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign bad_coord  = bad_q;
    assign fifo_level = level_q;

`ifdef DISP_WRITER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // frame counter wraps; drop counter saturates (two drops can coincide)
    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(accept && last_q);
        drop_sum    = {1'b0, drop_cnt_q} + 17'(drop_ovf) + 17'(drop_bad);
        drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule
